iir_out_stage: RTL and testbench
================================

# iir_out_stage

Output stage placed directly downstream of `opti_top`. It takes the filtered 24-bit samples (`data_out` / `data_valid_out`), applies a runtime power-of-two gain with saturation, and buffers the results in a synchronous FIFO. A consumer drains the FIFO through a valid/ready handshake. The filter cannot stall, so the FIFO absorbs consumer back-pressure and accounts for any samples it has to drop.

## Interface
Parameters:
- `DATA_W`, 24: sample width, two's complement.
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 4.
- `CNT_W`, 16: width of the drop counter.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  DATA_W  filtered sample from `opti_top.data_out`.
- `data_valid_in`  in  1  sample strobe from `opti_top.data_valid_out`.
- `gain_sh`  in  2  left-shift amount, 0–3; sampled on the cycle `data_valid_in` is high.
- `clr`  in  1  synchronous clear of FIFO, flags and counters.
- `m_data`  out  DATA_W  head-of-FIFO sample.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  consumer accepts `m_data` when `m_valid && m_ready`.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `ovf`  out  1  sticky flag; set when a sample is dropped.
- `drop_cnt`  out  CNT_W  dropped-sample count; saturates at all-ones.
- `peak_abs`  out  DATA_W  largest magnitude seen. Present only with `IIR_OUT_PEAK_EN`.

## Operation
- **Stage 1 (scale register).** On `data_valid_in`, compute `s = data_in <<< gain_sh` at DATA_W+3 bits, then clamp:
  - If s > 2^(DATA_W-1)-1, the result is 8388607.
  - If s < -2^(DATA_W-1), the result is -8388608.
  - Register the clamped result together with a valid bit `v1`.
- **Stage 2 (FIFO write).** When `v1` is high, write the registered value.
- **Full FIFO.** If the FIFO is full and no pop occurs in the same cycle, the sample is dropped, `ovf` is set, and `drop_cnt` increments (saturating).
- **Full FIFO with pop.** If full and a pop occurs in the same cycle, the write is accepted and `level` stays at DEPTH.
- **Pop.** A pop happens when `m_valid && m_ready`. `rd_ptr` advances and wraps modulo DEPTH; `wr_ptr` also wraps.
- **Read timing.** First-word-fall-through: `m_data` = `mem[rd_ptr]` combinationally, and `m_valid` = (`level` != 0).
- **Empty FIFO.** When empty, `m_data` is don't-care and a pop cannot occur. A write into an empty FIFO produces no same-cycle bypass.
- **`clr`.** Empties the FIFO, clears `v1`, `ovf`, `drop_cnt` and `peak_abs`, and does not affect memory contents. If `data_valid_in` arrives on the same cycle as `clr`, that sample is discarded.
- **Consumer expectations.** A consumer holds off while `m_valid` is 0. `m_data` must stay stable while `m_valid && !m_ready`.

## Timing
- **Latency.** `data_valid_in` sampled at edge N gives `v1` high after edge N. The FIFO write happens at edge N+1, so `m_valid` rises after edge N+1 when the FIFO was empty: 2 cycles input-to-output.
- **Throughput.** One sample per clock in and one per clock out.
- **`level`.** Updates at the edge: +1 on write only, −1 on pop only, unchanged on both or neither.
- **Reset values (`rst_n` low, asynchronous).**
  - Pointers, `level`, `v1`, `ovf`, `drop_cnt` and `peak_abs` are 0.
  - `m_valid` is 0 and `m_data` is 0.
  - Mid-stream reset discards all buffered and in-flight samples.
- **`gain_sh` changes.** These take effect only on the next valid sample; in-flight samples keep the gain they were sampled with.

## Configuration
- `IIR_OUT_PEAK_EN`
  - **Defined:** the `peak_abs` port and register exist. On each stage-1 valid, `peak_abs <= max(peak_abs, |sat value|)`, where |-8388608| = 8388608 unsigned. The update uses the post-saturation value and includes dropped samples. `clr` or reset sets it to 0.
  - **Undefined:** the port is absent and no comparator or register is built. All other behaviour is identical.

## Structure
- **Package `iir_pkg`:**
  - `DATA_W` default constant.
  - `SAT_MAX` = 2^(DATA_W-1)-1 and `SAT_MIN` = -2^(DATA_W-1).
  - A saturating-shift function shared with future output stages.
- **Sub-module `iir_sync_fifo`:**
  - Parameters DEPTH and DATA_W.
  - Handles the memory array, pointers, `level`, and the full/empty logic.
  - `iir_out_stage` wraps it with the scale register, drop accounting and peak tracker.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-stream with 5 samples buffered. All outputs are 0; after release `m_valid` stays 0 until new input arrives.
- **Latency.** With `gain_sh`=0, `m_ready`=1, apply a single `data_in`=100. `m_valid` is high exactly 2 cycles later with `m_data`=100, and `level` returns to 0.
- **Saturation.** With `gain_sh`=2, apply 3145728, -3145728, 1000 and -1. The outputs are 8388607, -8388608, 4000 and -4, in order.
- **Overflow.** With `m_ready`=0 and DEPTH=16, push 20 consecutive samples 1..20. Expect `level`=16, `ovf`=1 and `drop_cnt`=4; draining yields 1..16 in order.
- **Simultaneous pop and write.** Fill to 16, then push 8 more with `m_ready`=1 throughout. Expect no drops, `level` holding at 16, and output order preserved.
- **Peak and clear** (`IIR_OUT_PEAK_EN`). Inputs -5000, 300 and 4999 with `gain_sh`=0 give `peak_abs`=5000. Pulse `clr`: `peak_abs`, `level`, `ovf` and `drop_cnt` all go to 0 on the next cycle.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared constants and the saturating power-of-two gain used by IIR output stages.
package iir_pkg;

  localparam int DATA_W = 24;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Shift at DATA_W+3 bits so a gain of up to 8x never wraps before the clamp.
  function automatic logic signed [DATA_W-1:0] sat_shl(
    input logic signed [DATA_W-1:0] x,
    input logic        [1:0]        sh
  );
    logic signed [DATA_W+2:0] s;
    logic signed [DATA_W+2:0] hi;
    logic signed [DATA_W+2:0] lo;
    s  = {{3{x[DATA_W-1]}}, x};
    s  = s <<< sh;
    hi = {3'b000, SAT_MAX};
    lo = {3'b111, SAT_MIN};
    if (s > hi)      return SAT_MAX;
    else if (s < lo) return SAT_MIN;
    else             return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/iir_out_stage_if.sv
// Consumer-side valid/ready stream of the IIR output stage.
interface iir_out_stage_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/iir_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write into a full FIFO is taken only alongside a pop.
module iir_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o,
  output logic                     wr_acc_o
);
  import iir_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q, level_d;
  logic              full, push, pop;

  assign empty_o = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign pop     = rd_en_i && !empty_o && !clr_i;
  assign push    = wr_en_i && (!full || pop) && !clr_i;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Storage is never reset or cleared; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign wr_acc_o  = push;

endmodule

// File: rtl/iir_out_stage.sv
// Gain/saturation register feeding a FIFO with drop accounting for a non-stallable filter.
// Optional peak-magnitude tracker enabled by defining IIR_OUT_PEAK_EN.
module iir_out_stage #(
  parameter int DATA_W = iir_pkg::DATA_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid_in,
  input  logic [1:0]               gain_sh,
  input  logic                     clr,
  iir_out_stage_if.master          m_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [CNT_W-1:0]         drop_cnt
`ifdef IIR_OUT_PEAK_EN
  ,
  output logic [DATA_W-1:0]        peak_abs
`endif
);
  import iir_pkg::*;

  logic signed [DATA_W-1:0] sat_d, sat_q;
  logic                     v1_q;
  logic                     ovf_q;
  logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;
  logic                     fifo_empty, wr_acc, drop;
  logic [DATA_W-1:0]        fifo_rd;

  // Stage 1: scale and clamp; gain is captured with the sample it applies to.
  assign sat_d = sat_shl(data_in, gain_sh);

  always_ff @(posedge clk) begin
    if (data_valid_in) sat_q <= sat_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     v1_q <= 1'b0;
    else if (clr)   v1_q <= 1'b0;
    else            v1_q <= data_valid_in;
  end

  // Stage 2: FIFO write
  iir_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .wr_en_i   (v1_q),
    .wr_data_i (sat_q),
    .rd_en_i   (m_if.m_ready),
    .rd_data_o (fifo_rd),
    .level_o   (level),
    .empty_o   (fifo_empty),
    .wr_acc_o  (wr_acc)
  );

  assign m_if.m_data  = fifo_rd;
  assign m_if.m_valid = !fifo_empty;

  assign drop       = v1_q && !clr && !wr_acc;
  assign drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      ovf_q      <= 1'b1;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

`ifdef IIR_OUT_PEAK_EN
  logic [DATA_W-1:0] abs_d, peak_q;

  // Negating SAT_MIN wraps to 1000..0, which read unsigned is exactly its magnitude.
  assign abs_d = sat_q[DATA_W-1] ? $unsigned(-sat_q) : $unsigned(sat_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         peak_q <= '0;
    else if (clr)                       peak_q <= '0;
    else if (v1_q && (abs_d > peak_q))  peak_q <= abs_d;
  end

  assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_iir_out_stage.sv
// Randomized and directed bench for iir_out_stage against a queue-based reference model.
module tb_iir_out_stage;
  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic                 dv = 1'b0;
  logic [1:0]           gain = 2'd0;
  logic                 clr = 1'b0;
  logic [LW-1:0]        level;
  logic                 ovf;
  logic [CW-1:0]        drop_cnt;
`ifdef IIR_OUT_PEAK_EN
  logic [DW-1:0]        peak_abs;
`endif

  always #5 clk = ~clk;

  iir_out_stage_if #(.DATA_W(DW)) mif();

  iir_out_stage #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (din),
    .data_valid_in (dv),
    .gain_sh       (gain),
    .clr           (clr),
    .m_if          (mif),
    .level         (level),
    .ovf           (ovf),
    .drop_cnt      (drop_cnt)
`ifdef IIR_OUT_PEAK_EN
    ,
    .peak_abs      (peak_abs)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: a sample in flight, the FIFO contents and the status counters.
  int q[$];
  bit mv1 = 0;
  int mval = 0;
  bit movf = 0;
  int mdrop = 0;
  int mpeak = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  function automatic int ref_sat(input int x, input int sh);
    longint s, hi, lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    s  = longint'(x) * (longint'(1) << sh);
    if (s > hi) return int'(hi);
    if (s < lo) return int'(lo);
    return int'(s);
  endfunction

  task automatic model_reset();
    q.delete();
    mv1 = 0; movf = 0; mdrop = 0; mpeak = 0;
  endtask

  task automatic check_outputs();
    check("m_valid", longint'(mif.m_valid), longint'(q.size() != 0));
    check("level", longint'(level), longint'(q.size()));
    check("ovf", longint'(ovf), longint'(movf));
    check("drop_cnt", longint'(drop_cnt), longint'(mdrop));
    if (q.size() != 0) check("m_data", longint'($signed(mif.m_data)), longint'(q[0]));
`ifdef IIR_OUT_PEAK_EN
    check("peak_abs", longint'(peak_abs), longint'(mpeak));
`endif
  endtask

  // Compare, clock once, then advance the model by the rules for that edge.
  task automatic step();
    check_outputs();
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      bit pop;
      int a;
      pop = (q.size() != 0) && mif.m_ready;
      if (pop) void'(q.pop_front());
      if (mv1) begin
        if (q.size() < DEPTH) q.push_back(mval);
        else begin
          movf = 1;
          if (mdrop < (1 << CW) - 1) mdrop++;
        end
        a = (mval < 0) ? -mval : mval;
        if (a > mpeak) mpeak = a;
      end
      mv1 = dv;
      if (dv) mval = ref_sat(int'(din), int'(gain));
    end
    #1;
  endtask

  task automatic push(input int v);
    dv  = 1'b1;
    din = DW'(v);
    step();
    dv  = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  int sat_in[4]  = '{3145728, -3145728, 1000, -1};
  int sat_exp[4] = '{8388607, -8388608, 4000, -4};

  initial begin
    mif.m_ready = 1'b0;
    #12;
    check("rst_m_valid", longint'(mif.m_valid), 0);
    check("rst_m_data", longint'(mif.m_data), 0);
    check("rst_level", longint'(level), 0);
    check("rst_ovf", longint'(ovf), 0);
    check("rst_drop", longint'(drop_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Latency of a lone sample
    gain = 2'd0; mif.m_ready = 1'b1;
    push(100);
    check("lat_c1_valid", longint'(mif.m_valid), 0);
    step();
    check("lat_c2_valid", longint'(mif.m_valid), 1);
    check("lat_c2_data", longint'($signed(mif.m_data)), 100);
    step();
    check("lat_level", longint'(level), 0);

    // Saturation with gain 4
    gain = 2'd2; mif.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(sat_in[i]);
    step(); step();
    mif.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("sat_out", longint'($signed(mif.m_data)), longint'(sat_exp[i]));
      step();
    end

    // Overflow
    gain = 2'd0; mif.m_ready = 1'b0;
    for (int i = 1; i <= 20; i++) push(i);
    step(); step();
    check("ovf_level", longint'(level), 16);
    check("ovf_flag", longint'(ovf), 1);
    check("ovf_drops", longint'(drop_cnt), 4);
    mif.m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("ovf_drain", longint'($signed(mif.m_data)), longint'(i));
      step();
    end
    check("ovf_empty", longint'(level), 0);

    pulse_clr();
    check("clr_ovf", longint'(ovf), 0);
    check("clr_drops", longint'(drop_cnt), 0);

    // Full FIFO with pop and write on the same edge
    mif.m_ready = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      if (i == 18) mif.m_ready = 1'b1;
      push(i * 7);
      if (i >= 18) check("sim_level", longint'(level), 16);
    end
    step();
    check("sim_level_tail", longint'(level), 16);
    check("sim_drops", longint'(drop_cnt), 0);
    for (int i = 0; i < 18; i++) step();
    check("sim_empty", longint'(level), 0);

`ifdef IIR_OUT_PEAK_EN
    pulse_clr();
    gain = 2'd0; mif.m_ready = 1'b0;
    push(-5000); push(300); push(4999);
    step(); step();
    check("peak_val", longint'(peak_abs), 5000);
`endif

    // Clear with data buffered and an overflow recorded
    mif.m_ready = 1'b0;
    for (int i = 0; i < 18; i++) push(i + 50);
    step(); step();
    pulse_clr();
    check("clr2_level", longint'(level), 0);
    check("clr2_ovf", longint'(ovf), 0);
    check("clr2_drops", longint'(drop_cnt), 0);
    check("clr2_valid", longint'(mif.m_valid), 0);
`ifdef IIR_OUT_PEAK_EN
    check("clr2_peak", longint'(peak_abs), 0);
`endif

    // Random traffic: slow consumer first, then a fast one
    for (int c = 0; c < 3000; c++) begin
      dv  = ($urandom_range(0, 3) != 0);
      din = ($urandom_range(0, 1) != 0) ? DW'($urandom) : DW'($urandom_range(0, 4000) - 2000);
      gain = 2'($urandom_range(0, 3));
      mif.m_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 299) == 0);
      step();
    end
    dv = 1'b0; clr = 1'b0;

    // Mid-stream asynchronous reset with five samples buffered
    pulse_clr();
    mif.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(i + 900);
    step(); step();
    check("pre_rst_level", longint'(level), 5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mrst_m_valid", longint'(mif.m_valid), 0);
    check("mrst_m_data", longint'(mif.m_data), 0);
    check("mrst_level", longint'(level), 0);
    check("mrst_ovf", longint'(ovf), 0);
    check("mrst_drop", longint'(drop_cnt), 0);
`ifdef IIR_OUT_PEAK_EN
    check("mrst_peak", longint'(peak_abs), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    mif.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_idle", longint'(mif.m_valid), 0);
      step();
    end
    push(-77);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
